// File: rtl/inverter_pkg.sv
// Shared definitions for the inverter pipeline: the mode encodings
// used by the configuration register and the transform logic.
package inverter_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_INV  = 2'b01,
        MODE_MASK = 2'b10,
        MODE_ALT  = 2'b11
    } mode_t;

endpackage

// File: rtl/inv_stage.sv
// One pipeline slot: a data register plus its valid bit, frozen while
// the downstream consumer stalls the pipe.
module inv_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             valid_d,
    input  logic [WIDTH-1:0] data_d,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (!hold) begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/inverter_pipe.sv
// Configurable bit-inverting pipeline with valid/ready handshaking, a
// STAGES-deep register chain and a wrapping count of accepted words.
import inverter_pkg::*;

module inverter_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [1:0]       cfg_mode,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt
);

    logic             stall;
    logic             accept;
    mode_t            mode_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] xform;

    logic [STAGES:0]  valid_chain;
    logic [WIDTH-1:0] data_chain [STAGES+1];

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // Configuration takes effect after the edge that loads it, so a word
    // accepted on that same edge still sees the previous mode and mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_PASS;
            mask_q <= '0;
        end else if (cfg_load) begin
            mode_q <= mode_t'(cfg_mode);
            mask_q <= cfg_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (accept) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    // Alternate mode keys off the count of words accepted before this one.
    always_comb begin
        xform = in_data;
        case (mode_q)
            MODE_PASS: xform = in_data;
            MODE_INV:  xform = ~in_data;
            MODE_MASK: xform = in_data ^ mask_q;
            MODE_ALT:  xform = word_cnt[0] ? in_data : ~in_data;
            default:   xform = in_data;
        endcase
    end

    assign valid_chain[0] = accept;
    assign data_chain[0]  = accept ? xform : '0;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        inv_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .hold    (stall),
            .valid_d (valid_chain[g]),
            .data_d  (data_chain[g]),
            .valid_q (valid_chain[g+1]),
            .data_q  (data_chain[g+1])
        );
    end

    assign out_valid = valid_chain[STAGES];
    assign out_data  = data_chain[STAGES];

endmodule

// File: tb/tb_inverter_pipe.sv
// Directed self-checking bench for inverter_pipe (WIDTH=8, STAGES=2),
// plus a CNT_W=2 instance for counter wrap.
module tb_inverter_pipe;

    logic       clk;
    logic       rst;
    logic       cfg_load;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_mask;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [15:0] word_cnt;

    logic       s_cfg_load;
    logic [1:0] s_cfg_mode;
    logic [7:0] s_cfg_mask;
    logic       s_in_valid;
    logic [7:0] s_in_data;
    logic       s_in_ready;
    logic       s_out_valid;
    logic [7:0] s_out_data;
    logic       s_out_ready;
    logic [1:0] s_word_cnt;

    int checks = 0;
    int errors = 0;

    inverter_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .cfg_mode  (cfg_mode),
        .cfg_mask  (cfg_mask),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
    );

    inverter_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(2)) dut_small (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (s_cfg_load),
        .cfg_mode  (s_cfg_mode),
        .cfg_mask  (s_cfg_mask),
        .in_valid  (s_in_valid),
        .in_data   (s_in_data),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ready (s_out_ready),
        .word_cnt  (s_word_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (word_cnt !== 16'd0 || out_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_regs: word_cnt %0d out_data %h expected 0 / 00", word_cnt, out_data);
        end
        checks++;
        if (s_word_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_small_cnt: got %0d expected 0", s_word_cnt);
        end
    endtask

    task automatic test_invert();
        out_ready = 1'b1;
        cfg_load = 1'b1; cfg_mode = 2'b01; in_valid = 1'b0;
        tick();
        cfg_load = 1'b0;
        in_valid = 1'b1; in_data = 8'h3C;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL invert_early: out_valid %b expected 0 at t+1", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL invert_out: valid %b data %h expected 1 / C3", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL invert_bubble: out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_mask();
        cfg_load = 1'b1; cfg_mode = 2'b10; cfg_mask = 8'h0F;
        tick();
        cfg_load = 1'b0;
        in_valid = 1'b1; in_data = 8'hAA;
        tick();
        in_data = 8'hFF;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL mask_aa: valid %b data %h expected 1 / A5", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hF0) begin
            errors++;
            $display("[TB] FAIL mask_ff: valid %b data %h expected 1 / F0", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_alternate();
        do_reset();
        out_ready = 1'b1;
        cfg_load = 1'b1; cfg_mode = 2'b11;
        tick();
        cfg_load = 1'b0;
        in_valid = 1'b1; in_data = 8'h00;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL alt_word0: valid %b data %h expected 1 / FF", out_valid, out_data);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || word_cnt !== 16'd3) begin
            errors++;
            $display("[TB] FAIL alt_word1: valid %b data %h cnt %0d expected 1 / 00 / 3", out_valid, out_data, word_cnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL alt_word2: valid %b data %h expected 1 / FF", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_back_to_back_stall();
        logic [7:0] words [4];
        logic [7:0] exp   [4];
        int idx;
        int oidx;
        int stall_cycles;
        words = '{8'h10, 8'h20, 8'h30, 8'h40};
        exp   = '{8'hEF, 8'hDF, 8'hCF, 8'hBF};
        idx = 0; oidx = 0; stall_cycles = 0;
        cfg_load = 1'b1; cfg_mode = 2'b01; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        cfg_load = 1'b0;
        for (int c = 0; c < 14; c++) begin
            out_ready = !(c >= 3 && c < 6);
            in_valid  = (idx < 4);
            in_data   = (idx < 4) ? words[idx] : 8'h00;
            #1;
            if (out_valid && !out_ready) begin
                stall_cycles++;
                checks++;
                if (in_ready !== 1'b0 || oidx >= 4 || out_data !== exp[oidx]) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: in_ready %b data %h expected 0 / %h", in_ready, out_data, (oidx < 4) ? exp[oidx] : 8'h00);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (oidx >= 4 || out_data !== exp[oidx]) begin
                    errors++;
                    $display("[TB] FAIL stall_order: got %h expected %h", out_data, (oidx < 4) ? exp[oidx] : 8'h00);
                end
                oidx++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (oidx !== 4 || idx !== 4 || stall_cycles !== 3) begin
            errors++;
            $display("[TB] FAIL stall_count: out %0d in %0d stalls %0d expected 4 / 4 / 3", oidx, idx, stall_cycles);
        end
    endtask

    task automatic test_cfg_same_edge();
        do_reset();
        out_ready = 1'b1;
        cfg_load = 1'b1; cfg_mode = 2'b01;
        in_valid = 1'b1; in_data = 8'h12;
        tick();
        cfg_load = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h12) begin
            errors++;
            $display("[TB] FAIL cfg_old: valid %b data %h expected 1 / 12", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hED) begin
            errors++;
            $display("[TB] FAIL cfg_new: valid %b data %h expected 1 / ED", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_reset_flight();
        int seen;
        out_ready = 1'b1;
        cfg_load = 1'b1; cfg_mode = 2'b01;
        tick();
        cfg_load = 1'b0;
        in_valid = 1'b1; in_data = 8'hA1;
        tick();
        in_data = 8'hA2;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || word_cnt !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flight_reset: valid %b cnt %0d ready %b expected 0 / 0 / 1", out_valid, word_cnt, in_ready);
        end
        tick();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("[TB] FAIL flight_leak: %0d valid cycles expected 0", seen);
        end
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h55 || word_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL flight_after: valid %b data %h cnt %0d expected 1 / 55 / 1", out_valid, out_data, word_cnt);
        end
        tick();
    endtask

    task automatic test_wrap();
        s_out_ready = 1'b1;
        s_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_in_data = 8'(i);
            tick();
        end
        checks++;
        if (s_word_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL wrap_4: got %0d expected 0", s_word_cnt);
        end
        s_in_data = 8'h04;
        tick();
        s_in_valid = 1'b0;
        checks++;
        if (s_word_cnt !== 2'd1) begin
            errors++;
            $display("[TB] FAIL wrap_5: got %0d expected 1", s_word_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_load = 1'b0; cfg_mode = 2'b00; cfg_mask = 8'h00;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        s_cfg_load = 1'b0; s_cfg_mode = 2'b00; s_cfg_mask = 8'h00;
        s_in_valid = 1'b0; s_in_data = 8'h00; s_out_ready = 1'b1;
        #2;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_invert();
        test_mask();
        test_alternate();
        test_back_to_back_stall();
        test_cfg_same_edge();
        test_reset_flight();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
